vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_if.sv | 16 +
 rtl/vga_counter.sv | 37 +++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: 800x600@60 (40 MHz pixel clock) constants and decode helper.
package vga_pkg;

    localparam int unsigned VGA_CNT_W          = 11;
    localparam int unsigned VGA_FRAME_W        = 16;

    localparam int unsigned VGA_HOR_TOTAL      = 1056;
    localparam int unsigned VGA_HOR_VISIBLE    = 800;
    localparam int unsigned VGA_HOR_SYNC_START = 840;
    localparam int unsigned VGA_HOR_SYNC_END   = 968;

    localparam int unsigned VGA_VER_TOTAL      = 628;
    localparam int unsigned VGA_VER_VISIBLE    = 600;
    localparam int unsigned VGA_VER_SYNC_START = 601;
    localparam int unsigned VGA_VER_SYNC_END   = 605;

    // Half-open window test: lo <= v < hi
    function automatic logic in_range(
        input logic [VGA_CNT_W-1:0] v,
        input logic [VGA_CNT_W-1:0] lo,
        input logic [VGA_CNT_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bus shared by the draw pipeline; 38 bits in the order
// hcount[10:0], vcount[10:0], hsync, hblnk, vsync, vblnk, rgb[11:0].
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_counter.sv
// Wrap counter with enable: counts 0..TERMINAL, exposes its next value and a
// one-cycle wrap strobe asserted in the enabled cycle that returns it to 0.
module vga_counter #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned TERMINAL = 1055
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    // Next-value and wrap decode; holds when disabled
    always_comb begin
        wrap       = en && (count == TERM);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + WIDTH'(1);
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters with registered sync and
// blanking decoded from next-state counts, plus frame start pulse and counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned HOR_TOTAL      = VGA_HOR_TOTAL,
    parameter int unsigned HOR_VISIBLE    = VGA_HOR_VISIBLE,
    parameter int unsigned HOR_SYNC_START = VGA_HOR_SYNC_START,
    parameter int unsigned HOR_SYNC_END   = VGA_HOR_SYNC_END,
    parameter int unsigned VER_TOTAL      = VGA_VER_TOTAL,
    parameter int unsigned VER_VISIBLE    = VGA_VER_VISIBLE,
    parameter int unsigned VER_SYNC_START = VGA_VER_SYNC_START,
    parameter int unsigned VER_SYNC_END   = VGA_VER_SYNC_END
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    vga_if.out                     out,
    output logic                   frame_start,
    output logic [VGA_FRAME_W-1:0] frame_cnt
);

    localparam logic [VGA_CNT_W-1:0] H_VIS = VGA_CNT_W'(HOR_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] H_SS  = VGA_CNT_W'(HOR_SYNC_START);
    localparam logic [VGA_CNT_W-1:0] H_SE  = VGA_CNT_W'(HOR_SYNC_END);
    localparam logic [VGA_CNT_W-1:0] V_VIS = VGA_CNT_W'(VER_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] V_SS  = VGA_CNT_W'(VER_SYNC_START);
    localparam logic [VGA_CNT_W-1:0] V_SE  = VGA_CNT_W'(VER_SYNC_END);

    logic [VGA_CNT_W-1:0]   h_count;
    logic [VGA_CNT_W-1:0]   h_next;
    logic                   h_wrap;
    logic [VGA_CNT_W-1:0]   v_count;
    logic [VGA_CNT_W-1:0]   v_next;
    logic                   v_wrap;
    logic                   hsync_q;
    logic                   hblnk_q;
    logic                   vsync_q;
    logic                   vblnk_q;
    logic [VGA_FRAME_W-1:0] frame_count;

    vga_counter #(
        .WIDTH    (VGA_CNT_W),
        .TERMINAL (HOR_TOTAL - 1)
    ) u_hcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    // h_wrap already includes en, so the vertical count steps once per line
    vga_counter #(
        .WIDTH    (VGA_CNT_W),
        .TERMINAL (VER_TOTAL - 1)
    ) u_vcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Sync/blank decoded from next counts so they line up with the registered counts;
    // v_wrap implies h_wrap, so it marks the return to pixel (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vsync_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (en) begin
            hsync_q     <= in_range(h_next, H_SS, H_SE);
            hblnk_q     <= (h_next >= H_VIS);
            vsync_q     <= in_range(v_next, V_SS, V_SE);
            vblnk_q     <= (v_next >= V_VIS);
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + VGA_FRAME_W'(1);
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

    assign out.hcount = h_count;
    assign out.vcount = v_count;
    assign out.hsync  = hsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vsync  = vsync_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = '0;
    assign frame_cnt  = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for line checks
// and a scaled-timing instance for frame, freeze, reset and wrap checks.
module tb_vga_timing_gen;

    localparam int D_HT = 1056, D_HV = 800, D_HSS = 840, D_HSE = 968;
    localparam int D_VT = 628,  D_VV = 600, D_VSS = 601, D_VSE = 605;
    localparam int S_HT = 20,   S_HV = 12,  S_HSS = 14,  S_HSE = 18;
    localparam int S_VT = 10,   S_VV = 6,   S_VSS = 7,   S_VSE = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fs_d, fs_s;
    logic [15:0] fc_d, fc_s;

    vga_if vif_d ();
    vga_if vif_s ();

    always #5 clk = ~clk;

    vga_timing_gen u_dut_d (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (vif_d),
        .frame_start (fs_d),
        .frame_cnt   (fc_d)
    );

    vga_timing_gen #(
        .HOR_TOTAL      (S_HT),
        .HOR_VISIBLE    (S_HV),
        .HOR_SYNC_START (S_HSS),
        .HOR_SYNC_END   (S_HSE),
        .VER_TOTAL      (S_VT),
        .VER_VISIBLE    (S_VV),
        .VER_SYNC_START (S_VSS),
        .VER_SYNC_END   (S_VSE)
    ) u_dut_s (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (vif_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    int   errors = 0;
    int   checks = 0;
    int   dh, dv, dfc, sh, sv, sfc;
    logic dfs, sfs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Positional reference model, advanced on every rising edge
    task automatic model_step();
        if (rst) begin
            dh = 0; dv = 0; dfc = 0; dfs = 1'b0;
            sh = 0; sv = 0; sfc = 0; sfs = 1'b0;
        end else if (en) begin
            dfs = 1'b0;
            if (dh == D_HT - 1) begin
                dh = 0;
                if (dv == D_VT - 1) begin
                    dv = 0; dfs = 1'b1; dfc = (dfc + 1) & 16'hFFFF;
                end else dv++;
            end else dh++;
            sfs = 1'b0;
            if (sh == S_HT - 1) begin
                sh = 0;
                if (sv == S_VT - 1) begin
                    sv = 0; sfs = 1'b1; sfc = (sfc + 1) & 16'hFFFF;
                end else sv++;
            end else sh++;
        end else begin
            dfs = 1'b0;
            sfs = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_inst(input string p,
                            input logic [10:0] h, input logic [10:0] v,
                            input logic hs, input logic hb, input logic vs, input logic vb,
                            input logic [11:0] rgb, input logic fs, input logic [15:0] fc,
                            input int eh, input int ev, input int hv, input int hss, input int hse,
                            input int vv, input int vss, input int vse,
                            input logic efs, input int efc);
        chk({p, "_hcount"}, 32'(h), 32'(eh));
        chk({p, "_vcount"}, 32'(v), 32'(ev));
        chk({p, "_hsync"},  32'(hs), (eh >= hss && eh < hse) ? 32'd1 : 32'd0);
        chk({p, "_hblnk"},  32'(hb), (eh >= hv) ? 32'd1 : 32'd0);
        chk({p, "_vsync"},  32'(vs), (ev >= vss && ev < vse) ? 32'd1 : 32'd0);
        chk({p, "_vblnk"},  32'(vb), (ev >= vv) ? 32'd1 : 32'd0);
        chk({p, "_rgb"},    32'(rgb), 32'd0);
        chk({p, "_fstart"}, 32'(fs), 32'(efs));
        chk({p, "_fcnt"},   32'(fc), 32'(efc));
    endtask

    task automatic check_all();
        chk_inst("d", vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.hblnk, vif_d.vsync,
                 vif_d.vblnk, vif_d.rgb, fs_d, fc_d, dh, dv, D_HV, D_HSS, D_HSE,
                 D_VV, D_VSS, D_VSE, dfs, dfc);
        chk_inst("s", vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.hblnk, vif_s.vsync,
                 vif_s.vblnk, vif_s.rgb, fs_s, fc_s, sh, sv, S_HV, S_HSS, S_HSE,
                 S_VV, S_VSS, S_VSE, sfs, sfc);
    endtask

    initial begin
        int   hs_cnt, hs_first, hs_last, hb_rise;
        int   vs_cnt, vb_cnt, bad_edge, pulses, last_fs, gap;
        int   vs_first, vs_last, vb_rise;
        logic prev_hb, prev_vs, prev_vb;

        // Reset state
        rst = 1'b1;
        en  = 1'b0;
        dh = 0; dv = 0; dfc = 0; dfs = 1'b0;
        sh = 0; sv = 0; sfc = 0; sfs = 1'b0;
        repeat (3) tick();
        check_all();

        // Release; first enabled edge gives (1,0)
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("first_hcount", 32'(vif_d.hcount), 32'd1);
        chk("first_vcount", 32'(vif_d.vcount), 32'd0);
        check_all();

        // One full default line
        hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; prev_hb = 1'b0;
        for (int i = 0; i < D_HT - 1; i++) begin
            tick();
            check_all();
            if (vif_d.vcount == 11'd0) begin
                if (vif_d.hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(vif_d.hcount);
                    hs_last = int'(vif_d.hcount);
                end
                if (vif_d.hblnk && !prev_hb) hb_rise = int'(vif_d.hcount);
                prev_hb = vif_d.hblnk;
            end
        end
        chk("line_hsync_len",   32'(hs_cnt),   32'd128);
        chk("line_hsync_first", 32'(hs_first), 32'd840);
        chk("line_hsync_last",  32'(hs_last),  32'd967);
        chk("line_hblnk_rise",  32'(hb_rise),  32'd800);
        chk("wrap_hcount",      32'(vif_d.hcount), 32'd0);
        chk("wrap_vcount",      32'(vif_d.vcount), 32'd1);
        chk("wrap_hsync",       32'(vif_d.hsync),  32'd0);
        chk("wrap_hblnk",       32'(vif_d.hblnk),  32'd0);

        // Scaled instance after 1056 edges: 5 frames done, at (16,2)
        chk("pre_rst_fcnt_s",   32'(fc_s), 32'd5);
        chk("pre_rst_hcount_s", 32'(vif_s.hcount), 32'd16);
        chk("pre_rst_vcount_s", 32'(vif_s.vcount), 32'd2);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        dh = 0; dv = 0; dfc = 0; dfs = 1'b0;
        sh = 0; sv = 0; sfc = 0; sfs = 1'b0;
        chk("async_hcount_s", 32'(vif_s.hcount), 32'd0);
        chk("async_fcnt_s",   32'(fc_s), 32'd0);
        chk("async_hcount_d", 32'(vif_d.hcount), 32'd0);
        chk("async_vcount_d", 32'(vif_d.vcount), 32'd0);
        check_all();
        tick();
        check_all();
        rst = 1'b0;

        // Two scaled frames
        vs_cnt = 0; vb_cnt = 0; bad_edge = 0; pulses = 0; last_fs = -1; gap = -1;
        vs_first = -1; vs_last = -1; vb_rise = -1; prev_vs = 1'b0; prev_vb = 1'b0;
        for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
            tick();
            check_all();
            if (fs_s) begin
                pulses++;
                if (last_fs >= 0) gap = i - last_fs;
                last_fs = i;
            end
            if (i < S_HT * S_VT) begin
                if (vif_s.vsync) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = int'(vif_s.vcount);
                    vs_last = int'(vif_s.vcount);
                end
                if (vif_s.vblnk) vb_cnt++;
                if (vif_s.vblnk && !prev_vb) vb_rise = int'(vif_s.vcount);
            end
            if ((vif_s.vsync != prev_vs || vif_s.vblnk != prev_vb) && vif_s.hcount != 11'd0)
                bad_edge++;
            prev_vs = vif_s.vsync;
            prev_vb = vif_s.vblnk;
        end
        chk("frame_pulses",    32'(pulses),   32'd2);
        chk("frame_gap",       32'(gap),      32'd200);
        chk("frame_cnt_2",     32'(fc_s),     32'd2);
        chk("frame_vsync_len", 32'(vs_cnt),   32'd40);
        chk("frame_vblnk_len", 32'(vb_cnt),   32'd80);
        chk("frame_vsync_v0",  32'(vs_first), 32'd7);
        chk("frame_vsync_v1",  32'(vs_last),  32'd8);
        chk("frame_vblnk_v",   32'(vb_rise),  32'd6);
        chk("frame_edge_h0",   32'(bad_edge), 32'd0);

        // Freeze on the last pixel of the frame
        repeat (S_HT * S_VT - 1) tick();
        chk("last_hcount", 32'(vif_s.hcount), 32'd19);
        chk("last_vcount", 32'(vif_s.vcount), 32'd9);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_all();
        end
        chk("frozen_hcount", 32'(vif_s.hcount), 32'd19);
        chk("frozen_vcount", 32'(vif_s.vcount), 32'd9);
        chk("frozen_fstart", 32'(fs_s), 32'd0);
        chk("frozen_vblnk",  32'(vif_s.vblnk), 32'd1);
        en = 1'b1;
        tick();
        chk("resume_hcount", 32'(vif_s.hcount), 32'd0);
        chk("resume_vcount", 32'(vif_s.vcount), 32'd0);
        chk("resume_fstart", 32'(fs_s), 32'd1);
        chk("resume_fcnt",   32'(fc_s), 32'd3);
        check_all();

        // Frame counter rollover from a preloaded 16'hFFFF
        en = 1'b0;
        force u_dut_s.frame_count = 16'hFFFF;
        tick();
        release u_dut_s.frame_count;
        sfc = 16'hFFFF;
        tick();
        chk("preload_fcnt", 32'(fc_s), 32'hFFFF);
        en = 1'b1;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            tick();
            check_all();
        end
        chk("roll_fstart", 32'(fs_s), 32'd1);
        chk("roll_fcnt",   32'(fc_s), 32'd0);
        chk("roll_hcount", 32'(vif_s.hcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
